// File: rtl/odelay_load_sequencer_pkg.sv
// Shared PHY definitions for the output-delay load sequencer.
package odelay_load_sequencer_pkg;

    localparam int unsigned DLY_W    = 5;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        WAIT_SAFE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/odelay_load_sequencer_lowest_set_enc.sv
// Lowest-set-bit encoder: index and valid flag for the lowest set bit of a mask.
module lowest_set_enc #(
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned LANE_BITS = 3
) (
    input  logic [NUM_LANES-1:0] mask,
    output logic [LANE_BITS-1:0] lowest_idx_c,
    output logic                 lowest_valid_c
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        lowest_idx_c   = '0;
        lowest_valid_c = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_idx_c   = LANE_BITS'(i);
                lowest_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/odelay_load_sequencer.sv
// Sequences buffered per-lane delay writes into pipelined taps, then applies
// them all with one shared set pulse so every lane changes in the same cycle.
module odelay_load_sequencer
    import odelay_load_sequencer_pkg::*;
#(
    parameter int unsigned     NUM_LANES     = 8,
    parameter int unsigned     LANE_BITS     = 3,
    parameter logic [DLY_W-1:0] DELAY_INIT   = '0,
    parameter int unsigned     SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [LANE_BITS-1:0] req_lane,
    input  logic [DLY_W-1:0]     req_delay,
    input  logic                 commit,
    input  logic                 safe,
    output logic                 busy,
    output logic                 done,
    output logic [DLY_W-1:0]     dly_out,
    output logic [NUM_LANES-1:0] dly_ld,
    output logic                 dly_set
);

    seq_state_t            state;
    logic [DLY_W-1:0]      shadow [NUM_LANES];
    logic [NUM_LANES-1:0]  pending;
    logic [SETTLE_W-1:0]   settle_cnt;

    logic [LANE_BITS-1:0]  lowest_idx_c;
    logic                  lowest_valid_c;
    logic                  accept_c;
    logic                  lane_in_range_c;
    logic [NUM_LANES-1:0]  req_onehot_c;
    logic [NUM_LANES-1:0]  pending_merged_c;
    logic [NUM_LANES-1:0]  lowest_onehot_c;
    logic [NUM_LANES-1:0]  pending_cleared_c;

    lowest_set_enc #(
        .NUM_LANES (NUM_LANES),
        .LANE_BITS (LANE_BITS)
    ) u_lowest_set_enc (
        .mask           (pending),
        .lowest_idx_c   (lowest_idx_c),
        .lowest_valid_c (lowest_valid_c)
    );

    // Request acceptance and pending-mask bookkeeping; out-of-range lanes are swallowed.
    assign accept_c          = (state == IDLE) && req_valid && req_ready;
    assign lane_in_range_c   = 32'(req_lane) < NUM_LANES;
    assign req_onehot_c      = (accept_c && lane_in_range_c) ? (NUM_LANES'(1) << req_lane) : '0;
    assign pending_merged_c  = pending | req_onehot_c;
    assign lowest_onehot_c   = lowest_valid_c ? (NUM_LANES'(1) << lowest_idx_c) : '0;
    assign pending_cleared_c = pending & ~lowest_onehot_c;

    // Shadow delay storage; reset value must match the taps' power-up delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                shadow[i] <= DELAY_INIT;
            end
        end else if (accept_c && lane_in_range_c) begin
            shadow[req_lane] <= req_delay;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            settle_cnt <= '0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dly_out    <= '0;
            dly_ld     <= '0;
            dly_set    <= 1'b0;
        end else begin
            done    <= 1'b0;
            dly_set <= 1'b0;
            dly_ld  <= '0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    pending   <= pending_merged_c;
                    if (commit) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (pending_merged_c == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (lowest_valid_c) begin
                        dly_out <= shadow[lowest_idx_c];
                        dly_ld  <= lowest_onehot_c;
                        pending <= pending_cleared_c;
                    end
                    if (pending_cleared_c == '0) begin
                        settle_cnt <= '0;
                        state      <= (SETTLE_CYCLES == 0) ? WAIT_SAFE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state <= WAIT_SAFE;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                WAIT_SAFE: begin
                    if (safe) begin
                        dly_set <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_odelay_load_sequencer.sv
// Scoreboard bench for odelay_load_sequencer: stimulus queues expected ld/set/done
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_odelay_load_sequencer;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned LANE_BITS = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [LANE_BITS-1:0] req_lane = '0;
    logic [4:0]           req_delay = '0;
    logic                 commit = 1'b0;
    logic                 safe = 1'b1;
    logic                 busy;
    logic                 done;
    logic [4:0]           dly_out;
    logic [NUM_LANES-1:0] dly_ld;
    logic                 dly_set;

    typedef struct {
        int         kind;   // 0 = ld, 1 = set, 2 = done
        logic [7:0] ld;
        logic [4:0] dly;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    int   e;

    odelay_load_sequencer #(
        .NUM_LANES     (NUM_LANES),
        .LANE_BITS     (LANE_BITS),
        .DELAY_INIT    (5'd0),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_lane  (req_lane),
        .req_delay (req_delay),
        .commit    (commit),
        .safe      (safe),
        .busy      (busy),
        .done      (done),
        .dly_out   (dly_out),
        .dly_ld    (dly_ld),
        .dly_set   (dly_set)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] ld, input logic [4:0] dly, input int c);
        exp_t x;
        x.kind = kind;
        x.ld   = ld;
        x.dly  = dly;
        x.cyc  = c;
        q.push_back(x);
    endtask

    task automatic check_evt(input int kind, input logic [7:0] ld, input logic [4:0] dly);
        exp_t x;
        if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d ld %0h at cycle %0d, expected none", kind, ld, cyc);
        end else begin
            x = q.pop_front();
            chk("evt_kind", 32'(kind), 32'(x.kind));
            chk("evt_cycle", 32'(cyc), 32'(x.cyc));
            if (x.kind == 0) begin
                chk("evt_ld", 32'(ld), 32'(x.ld));
                chk("evt_dly", 32'(dly), 32'(x.dly));
            end
        end
    endtask

    // Monitor: every visible ld, set or done must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (dly_ld != '0) check_evt(0, dly_ld, dly_out);
            if (dly_set)      check_evt(1, 8'h00, 5'd0);
            if (done)         check_evt(2, 8'h00, 5'd0);
        end
    end

    // Called at a negedge; presents one request for one cycle.
    task automatic write(input int lane, input int dly);
        req_valid = 1'b1;
        req_lane  = LANE_BITS'(lane);
        req_delay = 5'(dly);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic start_commit(output int edge_no);
        edge_no = cyc + 1;
        commit  = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk({name, "_drain"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_dly_out",   32'(dly_out),   32'd0);
        chk("rst_dly_ld",    32'(dly_ld),    32'd0);
        chk("rst_dly_set",   32'(dly_set),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Two lanes, loaded lowest first, then settle, set, done.
        write(3, 17);
        write(5, 9);
        start_commit(e);
        push(0, 8'h08, 5'd17, e + 1);
        push(0, 8'h20, 5'd9,  e + 2);
        push(1, 8'h00, 5'd0,  e + 5);
        push(2, 8'h00, 5'd0,  e + 6);
        @(negedge clk);
        commit = 1'b0;
        wait_drain("t1");

        // Repeat write to one lane: last value wins, single ld.
        write(2, 4);
        write(2, 30);
        start_commit(e);
        push(0, 8'h04, 5'd30, e + 1);
        push(1, 8'h00, 5'd0,  e + 4);
        push(2, 8'h00, 5'd0,  e + 5);
        @(negedge clk);
        commit = 1'b0;
        wait_drain("t2");

        // Empty commit: done only.
        start_commit(e);
        push(2, 8'h00, 5'd0, e + 1);
        @(negedge clk);
        commit = 1'b0;
        wait_drain("t3");

        // safe held low long after settle: set waits for it.
        safe = 1'b0;
        write(0, 11);
        start_commit(e);
        push(0, 8'h01, 5'd11, e + 1);
        @(negedge clk);
        commit = 1'b0;
        while (cyc < e + 23) @(negedge clk);
        chk("t4_busy_waiting", 32'(busy),    32'd1);
        chk("t4_no_set",       32'(dly_set), 32'd0);
        safe = 1'b1;
        push(1, 8'h00, 5'd0, e + 24);
        push(2, 8'h00, 5'd0, e + 25);
        wait_drain("t4");

        // Reset mid-LOAD: outputs clear at once, pending writes are lost.
        write(1, 6);
        write(4, 21);
        start_commit(e);
        push(0, 8'h02, 5'd6, e + 1);
        @(negedge clk);
        commit = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_dly_ld",   32'(dly_ld),    32'd0);
        chk("t5_rst_dly_out",  32'(dly_out),   32'd0);
        chk("t5_rst_busy",     32'(busy),      32'd0);
        chk("t5_rst_ready",    32'(req_ready), 32'd0);
        chk("t5_first_ld_seen", 32'(q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_commit(e);
        push(2, 8'h00, 5'd0, e + 1);
        @(negedge clk);
        commit = 1'b0;
        wait_drain("t5");

        // Request on the commit edge is included; commit and requests while busy are ignored.
        req_valid = 1'b1;
        req_lane  = 3'd7;
        req_delay = 5'd1;
        start_commit(e);
        push(0, 8'h80, 5'd1, e + 1);
        push(1, 8'h00, 5'd0, e + 4);
        push(2, 8'h00, 5'd0, e + 5);
        @(negedge clk);
        req_valid = 1'b0;
        commit    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_ready_busy", 32'(req_ready), 32'd0);
        commit    = 1'b1;
        req_valid = 1'b1;
        req_lane  = 3'd0;
        req_delay = 5'd5;
        @(negedge clk);
        commit    = 1'b0;
        req_valid = 1'b0;
        wait_drain("t6");
        repeat (4) @(negedge clk);
        start_commit(e);
        push(2, 8'h00, 5'd0, e + 1);
        @(negedge clk);
        commit = 1'b0;
        wait_drain("t6_after");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
